// File: rtl/flop_bank_arbiter.sv
// Round-robin arbiter between two requesters for a shared single-port flop register bank,
// plus a controller that sweeps zeros through every word of the bank on command.
module flop_bank_arbiter #(
   parameter  int DEPTH = 16,
   parameter  int DW    = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_valid,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_ready,
   output logic          a_rvalid,
   input  logic          b_valid,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_ready,
   output logic          b_rvalid,
   output logic [DW-1:0] rdata,
   input  logic          clear_start,
   output logic          busy,
   output logic          clear_done,
   output logic          bank_we,
   output logic [AW-1:0] bank_addr,
   output logic [DW-1:0] bank_wdata,
   input  logic [DW-1:0] bank_rdata
);

   typedef enum logic {SERVE, CLEAR} state_t;

   localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   state_t        state;
   state_t        next_state;
   logic [AW-1:0] sweep_cnt;
   logic          last_grant_b;
   logic          grant_a;
   logic          grant_b;
   logic          sweep_last;
   logic          a_in_range;
   logic          b_in_range;

   // Addresses past the last word only exist when DEPTH is not a power of two.
   assign a_in_range = {1'b0, a_addr} < DEPTH_LIM;
   assign b_in_range = {1'b0, b_addr} < DEPTH_LIM;
   assign sweep_last = (sweep_cnt == LAST_ADDR);

   assign a_ready = grant_a;
   assign b_ready = grant_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SERVE;
      end else begin
         state <= next_state;
      end
   end

   // Bank pins are held quiet while rst is high so an aborted sweep writes nothing more.
   always_comb begin
      next_state = state;
      grant_a    = 1'b0;
      grant_b    = 1'b0;
      bank_we    = 1'b0;
      bank_addr  = '0;
      bank_wdata = '0;
      busy       = 1'b0;
      clear_done = 1'b0;
      case (state)
         SERVE: begin
            if (clear_start) begin
               next_state = CLEAR;
            end else if (!rst) begin
               grant_a = a_valid && (!b_valid || last_grant_b);
               grant_b = b_valid && (!a_valid || !last_grant_b);
            end
            if (grant_a) begin
               bank_addr  = a_addr;
               bank_we    = a_we && a_in_range;
               bank_wdata = a_we ? a_wdata : '0;
            end else if (grant_b) begin
               bank_addr  = b_addr;
               bank_we    = b_we && b_in_range;
               bank_wdata = b_we ? b_wdata : '0;
            end
         end
         CLEAR: begin
            busy       = 1'b1;
            bank_we    = !rst;
            bank_addr  = sweep_cnt;
            clear_done = sweep_last && !rst;
            if (sweep_last) begin
               next_state = SERVE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sweep_cnt    <= '0;
         last_grant_b <= 1'b1;
         rdata        <= '0;
         a_rvalid     <= 1'b0;
         b_rvalid     <= 1'b0;
      end else begin
         a_rvalid <= grant_a && !a_we;
         b_rvalid <= grant_b && !b_we;
         if (state == CLEAR) begin
            sweep_cnt <= sweep_last ? '0 : sweep_cnt + 1'b1;
         end
         if (grant_a) begin
            last_grant_b <= 1'b0;
            if (!a_we) begin
               rdata <= a_in_range ? bank_rdata : '0;
            end
         end else if (grant_b) begin
            last_grant_b <= 1'b1;
            if (!b_we) begin
               rdata <= b_in_range ? bank_rdata : '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_flop_bank_arbiter.sv
// Self-checking bench for flop_bank_arbiter: behavioural bank, reference memory and
// a read scoreboard holding the data each accepted read must return.
module tb_flop_bank_arbiter;

   localparam int DEPTH = 16;
   localparam int DW    = 8;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          a_valid, a_we, b_valid, b_we;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_wdata, b_wdata;
   logic          a_ready, a_rvalid, b_ready, b_rvalid;
   logic [DW-1:0] rdata;
   logic          clear_start, busy, clear_done;
   logic          bank_we;
   logic [AW-1:0] bank_addr;
   logic [DW-1:0] bank_wdata, bank_rdata;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct packed {
      logic          is_b;
      logic [DW-1:0] data;
   } rd_t;

   rd_t           sb[$];
   logic [DW-1:0] mem     [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];
   logic          exp_last_b;
   logic          mem_init;

   flop_bank_arbiter #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ready(a_ready), .a_rvalid(a_rvalid),
      .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ready(b_ready), .b_rvalid(b_rvalid),
      .rdata(rdata), .clear_start(clear_start), .busy(busy), .clear_done(clear_done),
      .bank_we(bank_we), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
      .bank_rdata(bank_rdata)
   );

   always #5 clk = ~clk;

   // External flop bank: writes land on the rising edge, reads are combinational.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(8'h10 + i);
      end else if (bank_we) begin
         mem[bank_addr] <= bank_wdata;
      end
   end
   assign bank_rdata = mem[bank_addr];

   function automatic logic [1:0] model_grant(input logic av, input logic bv);
      logic ga, gb;
      ga = av && (!bv || exp_last_b);
      gb = bv && (!av || !exp_last_b);
      return {ga, gb};
   endfunction

   task automatic model_accept(input logic is_b, input logic we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] d);
      exp_last_b = is_b;
      if (we) ref_mem[addr] = d;
      else sb.push_back({is_b, ref_mem[addr]});
   endtask

   task automatic drive(input logic av, input logic aw, input logic [AW-1:0] aad,
                        input logic [DW-1:0] ad, input logic bv, input logic bw,
                        input logic [AW-1:0] bad, input logic [DW-1:0] bd);
      a_valid = av; a_we = aw; a_addr = aad; a_wdata = ad;
      b_valid = bv; b_we = bw; b_addr = bad; b_wdata = bd;
   endtask

   task automatic test_reset();
      drive(0, 0, '0, '0, 0, 0, '0, '0);
      clear_start = 1'b0;
      rst = 1'b1;
      mem_init = 1'b1;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(8'h10 + i);
      @(negedge clk);
      @(negedge clk);
      mem_init = 1'b0;
      exp_last_b = 1'b1;
      sb.delete();
      tests_run++;
      if ({a_rvalid, b_rvalid, rdata} !== 10'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_read: got %h expected 000", {a_rvalid, b_rvalid, rdata});
      end
      tests_run++;
      if ({busy, clear_done} !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL reset_sweep: got %b expected 00", {busy, clear_done});
      end
      tests_run++;
      if ({a_ready, b_ready, bank_we, bank_addr, bank_wdata} !== 15'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_bank: got %h expected 0000",
                  {a_ready, b_ready, bank_we, bank_addr, bank_wdata});
      end
      rst = 1'b0;
   endtask

   task automatic test_round_robin();
      rd_t        e;
      logic [1:0] g;
      for (int i = 0; i <= 4; i++) begin
         if (i > 0) begin
            e = sb.pop_front();
            tests_run++;
            if ({a_rvalid, b_rvalid, rdata} !== {!e.is_b, e.is_b, e.data}) begin
               tests_failed++;
               $display("[TB] FAIL rr_rdata[%0d]: got %h expected %h", i,
                        {a_rvalid, b_rvalid, rdata}, {!e.is_b, e.is_b, e.data});
            end
         end
         if (i < 4) begin
            drive(1, 0, AW'(i), '0, 1, 0, AW'(i + 8), '0);
            #1;
            g = model_grant(1'b1, 1'b1);
            tests_run++;
            if ({a_ready, b_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
               tests_failed++;
               $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", i,
                        {a_ready, b_ready}, ((i % 2 == 0) ? 2'b10 : 2'b01));
            end
            tests_run++;
            if (bank_addr !== (g[1] ? AW'(i) : AW'(i + 8))) begin
               tests_failed++;
               $display("[TB] FAIL rr_addr[%0d]: got %h expected %h", i, bank_addr,
                        (g[1] ? AW'(i) : AW'(i + 8)));
            end
            model_accept(g[0], 1'b0, g[0] ? AW'(i + 8) : AW'(i), '0);
            @(negedge clk);
         end else begin
            drive(0, 0, '0, '0, 0, 0, '0, '0);
         end
      end
   endtask

   task automatic test_write_read();
      rd_t e;
      drive(1, 1, 4'd3, 8'h5A, 0, 0, '0, '0);
      #1;
      tests_run++;
      if ({a_ready, b_ready, bank_we, bank_addr, bank_wdata} !== {3'b101, 4'd3, 8'h5A}) begin
         tests_failed++;
         $display("[TB] FAIL wr_accept: got %h expected %h",
                  {a_ready, b_ready, bank_we, bank_addr, bank_wdata}, {3'b101, 4'd3, 8'h5A});
      end
      model_accept(1'b0, 1'b1, 4'd3, 8'h5A);
      @(negedge clk);
      tests_run++;
      if ({a_rvalid, b_rvalid} !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL wr_no_rvalid: got %b expected 00", {a_rvalid, b_rvalid});
      end
      drive(0, 0, '0, '0, 1, 0, 4'd3, '0);
      #1;
      tests_run++;
      if ({a_ready, b_ready, bank_we, bank_addr} !== {3'b010, 4'd3}) begin
         tests_failed++;
         $display("[TB] FAIL rd_accept: got %h expected %h",
                  {a_ready, b_ready, bank_we, bank_addr}, {3'b010, 4'd3});
      end
      model_accept(1'b1, 1'b0, 4'd3, '0);
      @(negedge clk);
      drive(0, 0, '0, '0, 0, 0, '0, '0);
      e = sb.pop_front();
      tests_run++;
      if ({a_rvalid, b_rvalid, rdata} !== {!e.is_b, e.is_b, e.data}) begin
         tests_failed++;
         $display("[TB] FAIL rd_data: got %h expected %h",
                  {a_rvalid, b_rvalid, rdata}, {!e.is_b, e.is_b, e.data});
      end
   endtask

   task automatic test_clear();
      rd_t        e;
      logic [1:0] g;
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 1, AW'(i), 8'hFF, 0, 0, '0, '0);
         #1;
         tests_run++;
         if ({a_ready, bank_we, bank_addr, bank_wdata} !== {2'b11, AW'(i), 8'hFF}) begin
            tests_failed++;
            $display("[TB] FAIL fill[%0d]: got %h expected %h", i,
                     {a_ready, bank_we, bank_addr, bank_wdata}, {2'b11, AW'(i), 8'hFF});
         end
         model_accept(1'b0, 1'b1, AW'(i), 8'hFF);
         @(negedge clk);
      end
      drive(0, 0, '0, '0, 0, 0, '0, '0);
      clear_start = 1'b1;
      #1;
      tests_run++;
      if ({busy, bank_we, clear_done} !== 3'b000) begin
         tests_failed++;
         $display("[TB] FAIL clr_trigger: got %b expected 000", {busy, bank_we, clear_done});
      end
      @(negedge clk);
      clear_start = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         #1;
         tests_run++;
         if ({busy, bank_we, bank_addr, bank_wdata, clear_done} !==
             {2'b11, AW'(k), 8'h00, (k == DEPTH - 1)}) begin
            tests_failed++;
            $display("[TB] FAIL clr_step[%0d]: got %h expected %h", k,
                     {busy, bank_we, bank_addr, bank_wdata, clear_done},
                     {2'b11, AW'(k), 8'h00, (k == DEPTH - 1)});
         end
         ref_mem[k] = '0;
         @(negedge clk);
      end
      #1;
      tests_run++;
      if ({busy, clear_done, bank_we} !== 3'b000) begin
         tests_failed++;
         $display("[TB] FAIL clr_end: got %b expected 000", {busy, clear_done, bank_we});
      end
      for (int i = 0; i <= DEPTH; i++) begin
         if (i > 0) begin
            e = sb.pop_front();
            tests_run++;
            if ({a_rvalid, b_rvalid, rdata} !== {!e.is_b, e.is_b, e.data}) begin
               tests_failed++;
               $display("[TB] FAIL clr_read[%0d]: got %h expected %h", i - 1,
                        {a_rvalid, b_rvalid, rdata}, {!e.is_b, e.is_b, e.data});
            end
         end
         if (i < DEPTH) begin
            drive(0, 0, '0, '0, 1, 0, AW'(i), '0);
            g = model_grant(1'b0, 1'b1);
            model_accept(g[0], 1'b0, AW'(i), '0);
            @(negedge clk);
         end else begin
            drive(0, 0, '0, '0, 0, 0, '0, '0);
         end
      end
   endtask

   task automatic test_clear_vs_request();
      drive(1, 1, 4'd5, 8'hC3, 0, 0, '0, '0);
      clear_start = 1'b1;
      #1;
      tests_run++;
      if ({a_ready, bank_we} !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL cvr_trigger: got %b expected 00", {a_ready, bank_we});
      end
      @(negedge clk);
      clear_start = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         #1;
         tests_run++;
         if ({a_ready, busy} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL cvr_hold[%0d]: got %b expected 01", k, {a_ready, busy});
         end
         ref_mem[k] = '0;
         @(negedge clk);
      end
      #1;
      tests_run++;
      if ({a_ready, busy, bank_we, bank_addr, bank_wdata} !== {3'b101, 4'd5, 8'hC3}) begin
         tests_failed++;
         $display("[TB] FAIL cvr_serve: got %h expected %h",
                  {a_ready, busy, bank_we, bank_addr, bank_wdata}, {3'b101, 4'd5, 8'hC3});
      end
      model_accept(1'b0, 1'b1, 4'd5, 8'hC3);
      @(negedge clk);
      drive(0, 0, '0, '0, 0, 0, '0, '0);
   endtask

   task automatic test_reset_mid_sweep();
      rd_t        e;
      logic [1:0] g;
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 1, AW'(i), 8'(8'hA0 + i), 0, 0, '0, '0);
         #1;
         model_accept(1'b0, 1'b1, AW'(i), 8'(8'hA0 + i));
         @(negedge clk);
      end
      drive(0, 0, '0, '0, 0, 0, '0, '0);
      clear_start = 1'b1;
      @(negedge clk);
      clear_start = 1'b0;
      for (int k = 0; k < 7; k++) begin
         #1;
         tests_run++;
         if ({busy, bank_addr} !== {1'b1, AW'(k)}) begin
            tests_failed++;
            $display("[TB] FAIL abort_step[%0d]: got %h expected %h", k,
                     {busy, bank_addr}, {1'b1, AW'(k)});
         end
         ref_mem[k] = '0;
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_last_b = 1'b1;
      sb.delete();
      for (int c = 0; c < 3; c++) begin
         #1;
         tests_run++;
         if ({busy, clear_done, bank_we, bank_addr, a_rvalid, b_rvalid, rdata} !== 17'd0) begin
            tests_failed++;
            $display("[TB] FAIL abort_idle[%0d]: got %h expected 00000", c,
                     {busy, clear_done, bank_we, bank_addr, a_rvalid, b_rvalid, rdata});
         end
         @(negedge clk);
      end
      for (int i = 0; i <= DEPTH; i++) begin
         if (i > 0) begin
            e = sb.pop_front();
            tests_run++;
            if ({a_rvalid, b_rvalid, rdata} !== {!e.is_b, e.is_b, e.data}) begin
               tests_failed++;
               $display("[TB] FAIL abort_read[%0d]: got %h expected %h", i - 1,
                        {a_rvalid, b_rvalid, rdata}, {!e.is_b, e.is_b, e.data});
            end
         end
         if (i < DEPTH) begin
            drive(0, 0, '0, '0, 1, 0, AW'(i), '0);
            g = model_grant(1'b0, 1'b1);
            model_accept(g[0], 1'b0, AW'(i), '0);
            @(negedge clk);
         end else begin
            drive(0, 0, '0, '0, 0, 0, '0, '0);
         end
      end
   endtask

   task automatic test_restart_ignored();
      int busy_n = 0;
      int done_n = 0;
      int we_n   = 0;
      drive(0, 0, '0, '0, 0, 0, '0, '0);
      clear_start = 1'b1;
      @(negedge clk);
      for (int k = 0; k < DEPTH + 4; k++) begin
         clear_start = (k == 5);
         #1;
         busy_n += int'(busy);
         done_n += int'(clear_done);
         we_n   += int'(bank_we);
         @(negedge clk);
      end
      clear_start = 1'b0;
      tests_run++;
      if (busy_n != DEPTH || we_n != DEPTH) begin
         tests_failed++;
         $display("[TB] FAIL restart_len: got busy %0d writes %0d expected %0d each",
                  busy_n, we_n, DEPTH);
      end
      tests_run++;
      if (done_n != 1) begin
         tests_failed++;
         $display("[TB] FAIL restart_done: got %0d expected 1", done_n);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_round_robin();
      test_write_read();
      test_clear();
      test_clear_vs_request();
      test_reset_mid_sweep();
      test_restart_ignored();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/flop_bank_arbiter.md
# flop_bank_arbiter

Controller and two-port arbiter for a shared flop-based register bank built from asynchronous-clear D flip-flop cells. It time-multiplexes the bank's single read/write port between requester A (configuration loader) and requester B (inference datapath). Simultaneous requests are resolved round-robin. On command, it also runs a zero-fill sweep of the whole bank. The bank storage itself is external; this block drives its address, write-enable and write-data pins and samples its combinational read data.

## Interface

Parameters:

- DEPTH, 16, number of bank words; must be at least 2.
- DW, 8, word width in bits.
- AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- a_valid  in  1  requester A has a request.
- a_we  in  1  requester A request type: 1 = write, 0 = read.
- a_addr  in  AW  requester A word address.
- a_wdata  in  DW  requester A write data.
- a_ready  out  1  requester A request accepted this cycle.
- a_rvalid  out  1  read data valid for requester A.
- b_valid, b_we, b_addr, b_wdata, b_ready, b_rvalid: same meaning as the A signals, for requester B.
- rdata  out  DW  registered read data, shared by both requesters.
- clear_start  in  1  single-cycle pulse that starts the zero-fill sweep.
- busy  out  1  high while the sweep runs.
- clear_done  out  1  single-cycle pulse on the final sweep write.
- bank_we  out  1  bank write enable.
- bank_addr  out  AW  bank address.
- bank_wdata  out  DW  bank write data.
- bank_rdata  in  DW  bank combinational read data.

## Operation

States:

- SERVE (reset state)
  - Granting:
    - Only one valid: that requester is granted.
    - Both valid: the requester not granted most recently wins.
  - Acceptance and bank drive:
    - Grant is combinational: x_ready = grant to x. A transfer occurs when x_valid and x_ready are both high.
    - The granted request drives bank_addr. bank_we equals the granted x_we.
    - bank_wdata equals the granted x_wdata on writes and 0 otherwise.
  - Priority pointer:
    - last_grant updates only on an accepted transfer.
  - No request: bank_we=0, bank_addr=0, bank_wdata=0.
  - Sweep trigger:
    - clear_start in SERVE moves to CLEAR on the next edge.
    - clear_start outranks requests. In that cycle both ready outputs are 0 and the bank is not touched.
- CLEAR
  - a_ready=b_ready=0 and busy=1.
  - Each cycle: bank_we=1, bank_wdata=0, bank_addr=sweep counter. The counter starts at 0 and increments by 1.
  - Final write (counter = DEPTH-1):
    - clear_done=1 in that cycle.
    - Return to SERVE on the next edge.
    - Counter resets to 0.
  - clear_start while in CLEAR is ignored; there is no restart.
  - Held requests stay pending. They are served in SERVE under normal arbitration.

Read data:

- An accepted read captures bank_rdata into rdata at the same edge.
- x_rvalid pulses in the cycle after acceptance. rdata holds its value until the next accepted read.
- Writes do not alter rdata or the rvalid outputs.
- Out-of-range addresses (at or above DEPTH when DEPTH is not a power of two) are dropped: no bank_we, and a read returns 0. They are still accepted and counted for round-robin.

Reset values:

- State SERVE, sweep counter 0.
- last_grant = B, so A wins the first tie.
- rdata=0, a_rvalid=b_rvalid=0, busy=0, clear_done=0.
- bank_we=0, bank_addr=0, bank_wdata=0.

If rst is asserted mid-sweep, the sweep aborts at the next edge. No clear_done is issued and the bank contents are left partially cleared.

## Timing

- Accept-to-bank: same cycle, combinational grant. The bank samples the write at the accepting edge.
- Read latency: 1 cycle from acceptance to rvalid.
- Throughput: one request per cycle total. Under continuous dual contention grants alternate A, B, A, B.
- Sweep duration: clear_start at cycle t gives CLEAR writes at cycles t+1 to t+DEPTH. clear_done is high at t+DEPTH. Grants can occur again from t+DEPTH+1.
- busy is high exactly during cycles t+1 to t+DEPTH.
- clear_done is registered-state-derived, not combinational from clear_start.
- busy and clear_done never assert in the same cycle as any x_ready.

## Test plan

- Reset, then A writes 0x5A to addr 3. Then B reads addr 3. Expect: a_ready=1 in the write cycle. b_rvalid=1 one cycle after B is accepted, with rdata=0x5A.
- Both valid for 4 consecutive cycles, both reads, after reset. Expect grants A,B,A,B. Each rvalid appears 1 cycle after its grant, on the matching requester.
- Write 0xFF to all 16 addresses, then pulse clear_start. Expect:
  - busy high for 16 cycles.
  - bank_addr stepping 0..15 with bank_we=1 and bank_wdata=0.
  - clear_done only at addr 15.
  - Subsequent reads of any address return 0.
- clear_start and a_valid asserted in the same cycle. Expect a_ready=0 for 17 cycles. A is served in the first cycle after the sweep ends.
- Assert rst at sweep address 7. Expect next-edge outputs at their reset values and no clear_done. Addresses 0..6 read 0 and addresses 7..15 keep prior data.
- clear_start pulsed again mid-sweep. Expect the sweep length is unchanged at DEPTH writes and exactly one clear_done.
